seg7_scan_driver: RTL

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_scan_driver.sv | 113 +++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver: shadowed BCD digits, prescaled digit
// scan, optional leading-zero blanking and output polarity inversion.
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    err
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_bcd;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic [6:0]              r_seg;
  logic                    r_dpo;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_err;

  logic       w_tick;
  logic [3:0] w_code;
  logic       w_dp_sel;
  logic       w_lz;
  logic       w_acc;
  logic       w_bad;
  logic       w_blank;
  logic [6:0] w_seg;

  assign w_tick = (r_cnt == CNT_MAX);

  // Scan from the top digit down so w_acc means "this digit and all above are zero".
  always_comb begin
    w_code   = '0;
    w_dp_sel = 1'b0;
    w_lz     = 1'b0;
    w_acc    = 1'b1;
    w_bad    = 1'b0;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      w_acc = w_acc & (r_bcd[4*(NUM_DIGITS-1-j) +: 4] == 4'd0);
      if (IW'(NUM_DIGITS - 1 - j) == r_idx) begin
        w_code   = r_bcd[4*(NUM_DIGITS-1-j) +: 4];
        w_dp_sel = r_dp[NUM_DIGITS-1-j];
        w_lz     = w_acc;
      end
      w_bad = w_bad | (r_bcd[4*j +: 4] > 4'd9);
    end
  end

  assign w_blank = blank_lz && (r_idx != '0) && w_lz;

  always_comb begin
    w_seg = 7'h40;
    case (w_code)
      4'd0:    w_seg = 7'h3F;
      4'd1:    w_seg = 7'h06;
      4'd2:    w_seg = 7'h5B;
      4'd3:    w_seg = 7'h4F;
      4'd4:    w_seg = 7'h66;
      4'd5:    w_seg = 7'h6D;
      4'd6:    w_seg = 7'h7D;
      4'd7:    w_seg = 7'h07;
      4'd8:    w_seg = 7'h7F;
      4'd9:    w_seg = 7'h6F;
      default: w_seg = 7'h40;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_bcd <= '0;
      r_dp  <= '0;
      r_seg <= '0;
      r_dpo <= 1'b0;
      r_an  <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
      r_err <= w_bad;
      if (load) begin
        r_bcd <= bcd_in;
        r_dp  <= dp_in;
      end
      if (w_tick) begin
        r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + IW'(1);
        r_seg <= w_blank ? 7'h00 : w_seg;
        r_dpo <= w_dp_sel & ~w_blank;
        r_an  <= NUM_DIGITS'(1) << r_idx;
      end
    end
  end

  assign seg = (ACTIVE_LOW != 0) ? ~r_seg : r_seg;
  assign dp  = (ACTIVE_LOW != 0) ? ~r_dpo : r_dpo;
  assign an  = (ACTIVE_LOW != 0) ? ~r_an  : r_an;
  assign err = r_err;

endmodule
